// File: rtl/press_classifier_pkg.sv
// -----------------------------------------------------------------------------
// press_classifier_pkg
//
// Shared definitions for the button gesture classifier:
//   - state_t: 3-bit FSM state encoding (IDLE, PRESSED, LONG_HELD,
//     WAIT_SECOND, SECOND_PRESSED)
//   - default tick constants for the 2 kHz tick clock, kept in step with the
//     debouncer's timing notes
//   - is_held_state(): which states count as "button held"
// -----------------------------------------------------------------------------
package press_classifier_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  // Tick clock shared with the debouncer; all timing below is in ticks.
  localparam int TICK_HZ              = 2000;
  localparam int DEFAULT_LONG_TICKS   = 1000; // 0.5 s hold
  localparam int DEFAULT_DCLICK_TICKS = 500;  // 0.25 s double-click window
  localparam int DEFAULT_REPEAT_TICKS = 400;  // 0.2 s auto-repeat interval
  localparam int DEFAULT_CNT_W        = 11;   // holds the largest tick count

  // The button is physically down in these states.
  function automatic logic is_held_state(input state_t s);
    return (s == PRESSED) || (s == LONG_HELD) || (s == SECOND_PRESSED);
  endfunction

endpackage

// File: rtl/press_timer.sv
// -----------------------------------------------------------------------------
// press_timer
//
// CNT_W-bit up-counter with synchronous clear and count enable, plus an
// equality match against a limit supplied at run time. The classifier FSM
// owns one instance and picks the limit according to its current state.
//
// Ports:
//   clk     in   tick clock
//   reset   in   synchronous, active-high reset
//   clear   in   zero the counter on this edge (wins over enable)
//   enable  in   advance the counter by one on this edge
//   limit   in   CNT_W-bit compare value
//   match   out  count == limit (combinational)
// -----------------------------------------------------------------------------
module press_timer #(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             match
);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign match = (count == limit);

endmodule

// File: rtl/press_classifier.sv
// -----------------------------------------------------------------------------
// press_classifier
//
// Turns the debouncer's press/release edge pulses into gesture events for the
// game control FSM: short press (hit), long press (stand) and double click
// (new round). Runs on the 2 kHz tick clock; all timing is in ticks.
//
// Ports:
//   i_Clk_2kHz  in   2 kHz tick clock
//   i_Reset     in   synchronous, active-high reset (wins over all inputs)
//   i_Press     in   one-cycle pulse: debounced press edge
//   i_Release   in   one-cycle pulse: debounced release edge
//   o_Short     out  one-cycle pulse: short press recognised
//   o_Long      out  one-cycle pulse: long press recognised
//   o_Double    out  one-cycle pulse: double click recognised
//   o_Held      out  level: button currently considered held
//
// Build option:
//   PRESS_REPEAT_EN  when defined, o_Long re-fires every REPEAT_TICKS while
//                    the button stays down after a long press. When
//                    undefined, exactly one o_Long per long press.
// -----------------------------------------------------------------------------
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
  parameter int DCLICK_TICKS = DEFAULT_DCLICK_TICKS,
  parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS,
  parameter int CNT_W        = DEFAULT_CNT_W
) (
  input  logic i_Clk_2kHz,
  input  logic i_Reset,
  input  logic i_Press,
  input  logic i_Release,
  output logic o_Short,
  output logic o_Long,
  output logic o_Double,
  output logic o_Held
);

  // The counter starts at 0 in the first cycle of a state, so a match on
  // N-1 means N cycles have been spent there.
  localparam logic [CNT_W-1:0] LONG_LIMIT   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LIMIT = CNT_W'(DCLICK_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LIMIT = CNT_W'(REPEAT_TICKS - 1);

  state_t           state;
  state_t           next_state;
  logic             press_ok;
  logic             release_ok;
  logic             fire_short;
  logic             fire_long;
  logic             fire_double;
  logic             repeat_hit;
  logic             timer_clear;
  logic             timer_enable;
  logic             timer_match;
  logic [CNT_W-1:0] timer_limit;

  // A press and release in the same cycle carry no usable ordering, so both
  // are dropped.
  assign press_ok   = i_Press   & ~i_Release;
  assign release_ok = i_Release & ~i_Press;

  // Next-state and event decode. Release beats the long threshold and press
  // beats the double-click timeout because they are tested first.
  // NOTE: every signal driven here gets a default at the top of the block so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state   = state;
    fire_short   = 1'b0;
    fire_long    = 1'b0;
    fire_double  = 1'b0;
    repeat_hit   = 1'b0;
    timer_enable = 1'b0;
    timer_limit  = LONG_LIMIT;

    case (state)
      IDLE: begin
        if (press_ok) next_state = PRESSED;
      end

      PRESSED: begin
        timer_enable = 1'b1;
        timer_limit  = LONG_LIMIT;
        if (release_ok) begin
          next_state = WAIT_SECOND;
        end else if (timer_match) begin
          fire_long  = 1'b1;
          next_state = LONG_HELD;
        end
      end

      LONG_HELD: begin
        timer_limit = REPEAT_LIMIT;
`ifdef PRESS_REPEAT_EN
        timer_enable = 1'b1;
        if (release_ok) begin
          next_state = IDLE;
        end else if (timer_match) begin
          // Re-fire and restart the interval without leaving the state.
          fire_long  = 1'b1;
          repeat_hit = 1'b1;
        end
`else
        if (release_ok) next_state = IDLE;
`endif
      end

      WAIT_SECOND: begin
        timer_enable = 1'b1;
        timer_limit  = DCLICK_LIMIT;
        if (press_ok) begin
          next_state = SECOND_PRESSED;
        end else if (timer_match) begin
          fire_short = 1'b1;
          next_state = IDLE;
        end
      end

      SECOND_PRESSED: begin
        // Hold duration is deliberately not timed on the second press.
        if (release_ok) begin
          fire_double = 1'b1;
          next_state  = IDLE;
        end
      end

      default: next_state = IDLE;
    endcase
  end

  // Every state entry starts the counter from zero.
  assign timer_clear = (next_state != state) || repeat_hit;

  press_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (i_Clk_2kHz),
    .reset  (i_Reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .limit  (timer_limit),
    .match  (timer_match)
  );

  // State and all outputs registered together; o_Held follows the state
  // being entered so it tracks the button one cycle after each edge pulse.
  always_ff @(posedge i_Clk_2kHz) begin
    if (i_Reset) begin
      state    <= IDLE;
      o_Short  <= 1'b0;
      o_Long   <= 1'b0;
      o_Double <= 1'b0;
      o_Held   <= 1'b0;
    end else begin
      state    <= next_state;
      o_Short  <= fire_short;
      o_Long   <= fire_long;
      o_Double <= fire_double;
      o_Held   <= is_held_state(next_state);
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_press_classifier
//
// Table-driven bench for press_classifier with LONG_TICKS=8, DCLICK_TICKS=6,
// REPEAT_TICKS=4. Each table row is a 40-cycle gesture with absolute cycle
// numbers; cycle 0-2 always carry reset. Expected outputs for the next cycle
// are queued as each cycle's stimulus is driven and popped when the DUT's
// registered outputs for that cycle are sampled on the falling edge.
// Compile with +define+PRESS_REPEAT_EN to check the auto-repeat build.
// -----------------------------------------------------------------------------
module tb_press_classifier;

  localparam int LT     = 8;
  localparam int DT     = 6;
  localparam int RT     = 4;
  localparam int NCYC   = 40;
  localparam int NVEC   = 10;

  logic clk = 1'b0;
  logic rst;
  logic press;
  logic rel;
  logic short_p;
  logic long_p;
  logic double_p;
  logic held;

  always #5 clk = ~clk;

  press_classifier #(
    .LONG_TICKS   (LT),
    .DCLICK_TICKS (DT),
    .REPEAT_TICKS (RT),
    .CNT_W        (11)
  ) dut (
    .i_Clk_2kHz (clk),
    .i_Reset    (rst),
    .i_Press    (press),
    .i_Release  (rel),
    .o_Short    (short_p),
    .o_Long     (long_p),
    .o_Double   (double_p),
    .o_Held     (held)
  );

  // Stimulus cycles (-1 = unused) and expected event cycles / held windows
  // [on, off).
  typedef struct packed {
    int p0; int p1; int r0; int r1; int both; int rst_c;
    int e_short; int e_double; int e_l0; int e_l1; int e_l2;
    int h0_on; int h0_off; int h1_on; int h1_off;
  } vec_t;

  typedef struct packed {
    logic s; logic l; logic d; logic h;
  } out_t;

  vec_t  tbl   [NVEC];
  string names [NVEC];
  out_t  exp_q [$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  function automatic out_t expect_at(input vec_t v, input int c);
    out_t o;
    o.s = (c == v.e_short);
    o.l = (c == v.e_l0) || (c == v.e_l1) || (c == v.e_l2);
    o.d = (c == v.e_double);
    o.h = (c >= v.h0_on && c < v.h0_off) || (c >= v.h1_on && c < v.h1_off);
    return o;
  endfunction

  task automatic check(input string name, input int cyc, input out_t act,
                       input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got short/long/double/held=%b%b%b%b required %b%b%b%b",
               name, cyc, act.s, act.l, act.d, act.h, exp.s, exp.l, exp.d, exp.h);
    end
  endtask

  task automatic check_onehot(input string name, input int cyc, input out_t act);
    n_cmp++;
    if (!$onehot0({act.s, act.l, act.d})) begin
      n_fail++;
      $display("FAIL %s exclusive cycle %0d: got pulses=%b%b%b required at most one high",
               name, cyc, act.s, act.l, act.d);
    end
  endtask

  task automatic sample_and_compare(input string name, input int cyc);
    out_t act;
    out_t exp;
    @(negedge clk);
    act = '{s: short_p, l: long_p, d: double_p, h: held};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s scoreboard cycle %0d: got empty queue required an entry", name, cyc);
    end else begin
      exp = exp_q.pop_front();
      check(name, cyc, act, exp);
      check_onehot(name, cyc, act);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = tbl[idx];
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      #1;
      rst   = (cyc <= 2) || (cyc == v.rst_c);
      press = (cyc == v.p0) || (cyc == v.p1) || (cyc == v.both);
      rel   = (cyc == v.r0) || (cyc == v.r1) || (cyc == v.both);
      exp_q.push_back(expect_at(v, cyc + 1));
      // Cycle 0 outputs predate the first reset edge and are not checked.
      if (cyc > 0) sample_and_compare(names[idx], cyc);
      @(posedge clk);
    end
    #1;
    rst   = 1'b0;
    press = 1'b0;
    rel   = 1'b0;
    sample_and_compare(names[idx], NCYC);
    @(posedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    press = 1'b0;
    rel   = 1'b0;

    //                p0  p1  r0  r1 both rst  shrt dbl  l0  l1  l2  h0on h0off h1on h1off
    names[0] = "reset_press";
    tbl[0]   = '{  1, -1, -1, -1, -1, -1,  -1, -1, -1, -1, -1,  -1, -1,  -1, -1};
    names[1] = "short";
    tbl[1]   = '{ 10, -1, 13, -1, -1, -1,  20, -1, -1, -1, -1,  11, 14,  -1, -1};
    names[2] = "long";
`ifdef PRESS_REPEAT_EN
    tbl[2]   = '{ 10, -1, 30, -1, -1, -1,  -1, -1, 19, 23, 27,  11, 31,  -1, -1};
`else
    tbl[2]   = '{ 10, -1, 30, -1, -1, -1,  -1, -1, 19, -1, -1,  11, 31,  -1, -1};
`endif
    names[3] = "double";
    tbl[3]   = '{ 10, 15, 12, 17, -1, -1,  -1, 18, -1, -1, -1,  11, 13,  16, 18};
    names[4] = "release_at_long_threshold";
    tbl[4]   = '{ 10, -1, 18, -1, -1, -1,  25, -1, -1, -1, -1,  11, 19,  -1, -1};
    names[5] = "press_at_dclick_timeout";
    tbl[5]   = '{ 10, 18, 12, 20, -1, -1,  -1, 21, -1, -1, -1,  11, 13,  19, 21};
    names[6] = "reset_mid_gesture";
    tbl[6]   = '{ 10, -1, 16, -1, -1, 14,  -1, -1, -1, -1, -1,  11, 15,  -1, -1};
    names[7] = "press_release_same_cycle";
    tbl[7]   = '{ -1, -1, -1, -1, 10, -1,  -1, -1, -1, -1, -1,  -1, -1,  -1, -1};
    names[8] = "press_ignored_while_pressed";
    tbl[8]   = '{ 10, 12, 14, -1, -1, -1,  21, -1, -1, -1, -1,  11, 15,  -1, -1};
    names[9] = "long_second_press_no_long";
    tbl[9]   = '{ 10, 15, 12, 30, -1, -1,  -1, 31, -1, -1, -1,  11, 13,  16, 31};

    @(posedge clk);
    for (int i = 0; i < NVEC; i++) run_vec(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
